// File: rtl/uart_bit_timer.sv
// Bit-timing engine shared by the UART TX and RX paths: mid-bit and end-of-bit strobes, bit index, frame completion.
// Define UART_TIMER_OVERSAMPLE_EN to add the 16x sample_tick strobe (otherwise sample_tick is tied low).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1,
    localparam int FRAME_BITS  = 1 + DATA_BITS + PARITY_EN + STOP_BITS,
    localparam int BAUD_W      = $clog2(CLKS_PER_BIT),
    localparam int BIT_W       = $clog2(FRAME_BITS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             half_bit_flag,
    output logic             full_bit_flag,
    output logic [BIT_W-1:0] bit_index,
    output logic             frame_done,
    output logic             sample_tick
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [BAUD_W-1:0] HALF_CNT = BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [BAUD_W-1:0] LAST_CNT = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_cpb_range
            $error("uart_bit_timer: CLKS_PER_BIT out of range 4..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_range
            $error("uart_bit_timer: DATA_BITS out of range 5..9");
        end
        if (PARITY_EN < 0 || PARITY_EN > 1) begin : g_parity_range
            $error("uart_bit_timer: PARITY_EN must be 0 or 1");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_range
            $error("uart_bit_timer: STOP_BITS must be 1 or 2");
        end
    endgenerate

    state_t            state_r;
    logic [BAUD_W-1:0] baud_count_r;
    logic [BIT_W-1:0]  bit_index_r;

    logic run_s;
    logic half_s;
    logic full_s;
    logic done_s;

    // Strobes decode registered state only, so no input reaches an output combinationally.
    assign run_s  = (state_r == RUN);
    assign half_s = run_s && (baud_count_r == HALF_CNT);
    assign full_s = run_s && (baud_count_r == LAST_CNT);
    assign done_s = full_s && (bit_index_r == LAST_BIT);

    assign busy          = run_s;
    assign half_bit_flag = half_s;
    assign full_bit_flag = full_s;
    assign frame_done    = done_s;
    assign bit_index     = bit_index_r;

    // Frame FSM with baud and bit counters; abort outranks a back-to-back start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            baud_count_r <= '0;
            bit_index_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_count_r <= '0;
                    bit_index_r  <= '0;
                    if (start && !abort) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_r      <= IDLE;
                        baud_count_r <= '0;
                        bit_index_r  <= '0;
                    end else if (done_s) begin
                        baud_count_r <= '0;
                        bit_index_r  <= '0;
                        if (start) begin
                            state_r <= RUN;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (full_s) begin
                        state_r      <= RUN;
                        baud_count_r <= '0;
                        bit_index_r  <= bit_index_r + BIT_W'(1);
                    end else begin
                        state_r      <= RUN;
                        baud_count_r <= baud_count_r + BAUD_W'(1);
                        bit_index_r  <= bit_index_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    baud_count_r <= '0;
                    bit_index_r  <= '0;
                end
            endcase
        end
    end

`ifdef UART_TIMER_OVERSAMPLE_EN
    localparam int                OS_DIV  = CLKS_PER_BIT / 16;
    localparam logic [BAUD_W-1:0] OS_LAST = BAUD_W'(OS_DIV - 1);

    generate
        if (CLKS_PER_BIT < 16) begin : g_os_range
            $error("uart_bit_timer: oversampling needs CLKS_PER_BIT >= 16");
        end
    endgenerate

    logic [BAUD_W-1:0] os_count_r;
    logic [4:0]        os_index_r;
    logic              os_hit_s;

    // os_index saturates at 16 so the remainder cycles at the end of a bit produce no tick.
    assign os_hit_s    = run_s && (os_count_r == OS_LAST);
    assign sample_tick = os_hit_s && (os_index_r < 5'd16);

    // Oversampling divider, restarted whenever the next cycle begins a new bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            os_count_r <= '0;
            os_index_r <= 5'd0;
        end else if (!run_s || full_s) begin
            os_count_r <= '0;
            os_index_r <= 5'd0;
        end else if (os_hit_s) begin
            os_count_r <= '0;
            if (os_index_r < 5'd16) begin
                os_index_r <= os_index_r + 5'd1;
            end else begin
                os_index_r <= os_index_r;
            end
        end else begin
            os_count_r <= os_count_r + BAUD_W'(1);
            os_index_r <= os_index_r;
        end
    end
`else
    assign sample_tick = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bit_timer.sv
// Self-checking bench for uart_bit_timer: a frame-level arithmetic model checked every cycle plus pinned literal timings.
module tb_uart_bit_timer;

    localparam int CPB0 = 434;
    localparam int FB0  = 10;
    localparam int CPB1 = 20;
    localparam int FB1  = 12;

    logic clk   = 1'b0;
    logic rstn  = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic       busy0, half0, full0, done0, tick0;
    logic [3:0] bit0;
    logic       busy1, half1, full1, done1, tick1;
    logic [3:0] bit1;

    int     vectors     = 0;
    int     miscompares = 0;
    int     half1_cnt   = 0;
    longint cyc         = 0;
    longint t0          = 0;

    logic   act [2] = '{1'b0, 1'b0};
    longint beg [2] = '{64'd0, 64'd0};

    always #5 clk = ~clk;

    uart_bit_timer u_dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .busy(busy0), .half_bit_flag(half0), .full_bit_flag(full0),
        .bit_index(bit0), .frame_done(done0), .sample_tick(tick0)
    );

    uart_bit_timer #(
        .CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2)
    ) u_small (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .busy(busy1), .half_bit_flag(half1), .full_bit_flag(full1),
        .bit_index(bit1), .frame_done(done1), .sample_tick(tick1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cpb_of(int i);
        return (i == 0) ? CPB0 : CPB1;
    endfunction

    function automatic int fb_of(int i);
        return (i == 0) ? FB0 : FB1;
    endfunction

    // Model: a frame is "active" from its first cycle; everything else is position arithmetic.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act[0] <= 1'b0;
            act[1] <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (abort) begin
                    act[i] <= 1'b0;
                end else if (!act[i]) begin
                    if (start) begin
                        act[i] <= 1'b1;
                        beg[i] <= cyc + 1;
                    end
                end else if (cyc - beg[i] == longint'(fb_of(i) * cpb_of(i) - 1)) begin
                    if (start) beg[i] <= cyc + 1;
                    else       act[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [8:0] expect_out(int i);
        longint e;
        int     cpb, fb, pos, bi, os;
        logic   h, f, d, t;
        cpb = cpb_of(i);
        fb  = fb_of(i);
        if (!act[i]) return 9'd0;
        e   = cyc - beg[i];
        pos = int'(e % cpb);
        bi  = int'(e / cpb);
        h   = (pos == cpb / 2);
        f   = (pos == cpb - 1);
        d   = f && (bi == fb - 1);
        t   = 1'b0;
        os  = 0;
`ifdef UART_TIMER_OVERSAMPLE_EN
        os  = cpb / 16;
        t   = (pos < 16 * os) && ((pos % os) == os - 1);
`endif
        return {1'b1, h, f, d, t, 4'(bi)};
    endfunction

    task automatic check(string name, logic [8:0] got, logic [8:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b want %b (busy,half,full,done,tick,bit[3:0])",
                     name, cyc, got, want);
        end
    endtask

    task automatic lit(string name, logic [31:0] got, logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d (rel %0d): got %0d want %0d", name, cyc, cyc - t0, got, want);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("model_default", {busy0, half0, full0, done0, tick0, bit0}, expect_out(0));
        check("model_small",   {busy1, half1, full1, done1, tick1, bit1}, expect_out(1));
        if (half1) half1_cnt++;
    end

    task automatic at(longint n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        t0        = cyc;
        half1_cnt = 0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic nominal_frame();
        pulse_start();
        at(11);   lit("small_first_half", 32'(half1), 32'd1);
`ifdef UART_TIMER_OVERSAMPLE_EN
        at(27);   lit("tick_baud26", 32'(tick0), 32'd1);
`endif
        at(217);  lit("half_early", 32'(half0), 32'd0);
        at(218);  lit("half_218", 32'(half0), 32'd1);
        at(239);  lit("small_bit11", 32'(bit1), 32'd11);
        at(240);  lit("small_done_240", 32'(done1), 32'd1);
`ifdef UART_TIMER_OVERSAMPLE_EN
        at(432);  lit("tick_baud431", 32'(tick0), 32'd1);
        at(433);  lit("no_tick_baud432", 32'(tick0), 32'd0);
`endif
        at(434);  lit("full_434", 32'(full0), 32'd1);
        lit("small_half_count", 32'(half1_cnt), 32'd12);
        at(435);  lit("bit_after_first", 32'(bit0), 32'd1);
        at(4340); lit("done_4340", 32'(done0), 32'd1);
        lit("last_bit_index", 32'(bit0), 32'd9);
        at(4341); lit("idle_4341", 32'(busy0), 32'd0);
    endtask

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset_default", 32'({busy0, half0, full0, done0, tick0, bit0}), 32'd0);
        lit("reset_small",   32'({busy1, half1, full1, done1, tick1, bit1}), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        nominal_frame();
        repeat (10) @(negedge clk);

        // Back-to-back: start held through the first frame_done.
        @(negedge clk);
        t0    = cyc;
        start = 1'b1;
        at(4340); lit("b2b_done1", 32'(done0), 32'd1);
        at(4341);
        start = 1'b0;
        lit("b2b_bit_reset", 32'(bit0), 32'd0);
        lit("b2b_busy_held", 32'(busy0), 32'd1);
        at(8680); lit("b2b_done2", 32'(done0), 32'd1);
        at(8681); lit("b2b_idle", 32'(busy0), 32'd0);
        repeat (300) @(negedge clk);

        // Abort mid-frame, then abort+start together while idle.
        pulse_start();
        at(1000);
        abort = 1'b1;
        at(1001);
        abort = 1'b0;
        lit("abort_idle", 32'(busy0), 32'd0);
        lit("abort_bit", 32'(bit0), 32'd0);
        at(2000);
        start = 1'b1;
        abort = 1'b1;
        at(2001);
        start = 1'b0;
        abort = 1'b0;
        lit("abort_start_idle", 32'(busy0), 32'd0);
        lit("abort_start_idle_small", 32'(busy1), 32'd0);
        at(2002); lit("abort_start_still_idle", 32'(busy0), 32'd0);
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-frame, then a fresh nominal frame.
        pulse_start();
        at(500);
        lit("pre_reset_busy", 32'(busy0), 32'd1);
        #2 rstn = 1'b0;
        #1;
        lit("async_reset_default", 32'({busy0, half0, full0, done0, tick0, bit0}), 32'd0);
        lit("async_reset_small",   32'({busy1, half1, full1, done1, tick1, bit1}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        nominal_frame();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_bit_timer.md
# uart_bit_timer

Parametrised bit-timing engine shared by the UART TX and RX datapaths. It replaces the fixed-rate frame counter. It generates mid-bit and end-of-bit strobes, tracks the current bit index across a configurable frame, and signals frame completion. Frames are started and aborted explicitly, and frames can run back-to-back without a gap cycle.

## Interface
- CLKS_PER_BIT, 434: clock cycles per UART bit; legal range 4..65535 (434 = 50 MHz / 115200).
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_EN, 0: 1 adds one parity bit slot to the frame.
- STOP_BITS, 1: number of stop bits; 1 or 2.
- Derived values, not overridable:
  - FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS.
  - BAUD_W = $clog2(CLKS_PER_BIT).
  - BIT_W = $clog2(FRAME_BITS).
- clk  input  1  single clock; all state changes on posedge.
- rstn  input  1  reset; asynchronous assert, active-low.
- start  input  1  request to begin a frame; sampled on each posedge.
- abort  input  1  synchronous cancel of the frame in progress.
- busy  output  1  high while a frame is timing.
- half_bit_flag  output  1  one-cycle strobe at mid-bit.
- full_bit_flag  output  1  one-cycle strobe on the last cycle of each bit.
- bit_index  output  BIT_W  index of the current bit within the frame; 0 = start bit.
- frame_done  output  1  one-cycle strobe on the last cycle of the frame.
- sample_tick  output  1  16x oversampling strobe (see Configuration).

## Operation
- State machine states: IDLE and RUN. There is no other state.
- Internal counters: baud_count (BAUD_W bits) and bit_index.
- IDLE:
  - baud_count = 0, bit_index = 0, busy = 0.
  - All strobes are low.
  - start=1 and abort=0 → RUN on the next cycle, with baud_count=0 and bit_index=0.
- RUN:
  - baud_count counts 0..CLKS_PER_BIT-1, then wraps to 0. Each bit is exactly CLKS_PER_BIT cycles long.
  - half_bit_flag = RUN && baud_count == CLKS_PER_BIT/2 (integer division, floor).
  - full_bit_flag = RUN && baud_count == CLKS_PER_BIT-1.
  - Each full_bit_flag with bit_index < FRAME_BITS-1 increments bit_index.
  - frame_done = full_bit_flag && bit_index == FRAME_BITS-1.
  - On frame_done with start=0 → IDLE.
  - On frame_done with start=1 → remain in RUN; baud_count and bit_index reset to 0 (back-to-back frame).
  - start while in RUN, other than in the frame_done cycle, is ignored.
- abort:
  - abort=1 in any state → IDLE on the next cycle, with counters cleared.
  - abort takes priority over start, including when both are high in the frame_done cycle.
  - A strobe already decoding in the abort cycle still fires; no strobe fires afterwards.
- Asynchronous reset:
  - Assertion of rstn clears all state immediately, including mid-frame. All outputs read 0.
  - After release, the block is in IDLE and waits for start.
- Strobe decode: all strobes are combinational decodes of registered state only; no input-to-output combinational path exists.

## Timing
- Reset value of every output: busy=0, half_bit_flag=0, full_bit_flag=0, bit_index=0, frame_done=0, sample_tick=0.
- Cycle numbering: start sampled at the posedge ending cycle 0.
  - busy is high from cycle 1.
  - First half_bit_flag at cycle 1 + CLKS_PER_BIT/2.
  - First full_bit_flag at cycle CLKS_PER_BIT.
  - frame_done at cycle FRAME_BITS*CLKS_PER_BIT.
  - busy is low from cycle FRAME_BITS*CLKS_PER_BIT + 1, unless a back-to-back start was taken.
- Strobe counts per frame: exactly FRAME_BITS half_bit_flag pulses and FRAME_BITS full_bit_flag pulses.
- Back-to-back frames: the next frame's cycle 1 directly follows frame_done; busy stays high continuously.
- Arithmetic: all counter arithmetic is unsigned at the counter's own width. The bit_index increment never exceeds FRAME_BITS-1.

## Configuration
- Macro: UART_TIMER_OVERSAMPLE_EN.
- Defined:
  - Adds an os_count counter with divisor OS_DIV = CLKS_PER_BIT/16 (floor), plus a 5-bit os_index.
  - Both reset to 0 at the start of every bit (baud_count == 0).
  - sample_tick = RUN && os_count == OS_DIV-1 && os_index < 16.
  - Result: exactly 16 ticks per bit. Any remainder cycles fall at the end of the bit with no tick.
  - CLKS_PER_BIT must be ≥ 16; elaboration fails via $error otherwise.
- Undefined: sample_tick is tied to 0 and no oversampling logic is synthesised.

## Test plan
- Default parameters, start pulse at cycle 0:
  - half_bit_flag at cycle 218.
  - full_bit_flag at cycles 434, 868, …, 4340.
  - frame_done at cycle 4340; busy=0 at cycle 4341.
- CLKS_PER_BIT=20, DATA_BITS=8, PARITY_EN=1, STOP_BITS=2 (FRAME_BITS=12):
  - bit_index steps 0..11.
  - frame_done at cycle 240.
  - 12 half_bit_flag pulses, the first at cycle 11.
- Back-to-back, defaults: start held high through frame_done at cycle 4340:
  - busy never drops.
  - bit_index=0 at cycle 4341.
  - Second frame_done at cycle 8680.
- abort at cycle 1000 (defaults):
  - IDLE at cycle 1001, bit_index=0, no further strobes.
  - abort and start high together at cycle 2000: block stays IDLE.
- rstn asserted at cycle 500 mid-frame:
  - All outputs read 0 immediately.
  - After release, a start pulse produces a fresh frame with the nominal timing above.
- UART_TIMER_OVERSAMPLE_EN defined, defaults (OS_DIV=27):
  - 16 sample_tick pulses per bit, at baud_count 26, 53, …, 431.
  - No sample_tick at baud_count 432 or 433.
